// File: rtl/rv_reg_pkg.sv
// rv_reg_pkg: shared RV32E register-file types for the writeback path.
package rv_reg_pkg;
  localparam int REG_COUNT = 16;
  typedef logic [$clog2(REG_COUNT)-1:0] reg_loc_t;
  typedef logic [31:0] word_t;
  typedef struct packed {
    reg_loc_t loc;
    word_t    data;
  } wb_entry_t;
endpackage

// File: rtl/reg_writeback_queue_if.sv
// reg_access_execute: register-file write port plus the read data returned to execute.
interface reg_access_execute;
  import rv_reg_pkg::*;
  reg_loc_t write_loc;
  word_t    write_data;
  logic     do_write;
  word_t    read_data_1;
  word_t    read_data_2;
  modport out  (output write_loc, write_data, do_write, input read_data_1, read_data_2);
  modport file (input write_loc, write_data, do_write, output read_data_1, read_data_2);
endinterface

// File: rtl/reg_writeback_queue_fifo.sv
// reg_wb_fifo: circular buffer of writeback entries; entry views are rotated so index 0 is the head.
module reg_wb_fifo
  import rv_reg_pkg::*;
#(parameter int DEPTH = 4) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  wb_entry_t              push_entry,
  output wb_entry_t              head,
  output logic                   full,
  output logic                   empty,
  output logic     [DEPTH-1:0]   ent_valid,
  output reg_loc_t [DEPTH-1:0]   ent_loc,
  output word_t    [DEPTH-1:0]   ent_data
);
  localparam int AW = $clog2(DEPTH);
  wb_entry_t [DEPTH-1:0] mem;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0] count;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      mem    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) mem[wr_ptr] <= push_entry;
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      count  <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  assign head  = mem[rd_ptr];
  assign full  = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  // Age order lets the forwarding logic treat the highest matching index as newest.
  for (genvar g = 0; g < DEPTH; g++) begin : g_view
    assign ent_valid[g] = count > (AW+1)'(g);
    assign ent_loc[g]   = mem[rd_ptr + AW'(g)].loc;
    assign ent_data[g]  = mem[rd_ptr + AW'(g)].data;
  end
endmodule

// File: rtl/reg_writeback_queue.sv
// reg_writeback_queue: in-order writeback queue draining into the register file with operand forwarding.
// RF_WB_BYPASS_EN selects forwarding from the queue; otherwise queued operands raise hazard.
module reg_writeback_queue
  import rv_reg_pkg::*;
#(parameter int DEPTH = 4) (
  input  logic              clock,
  input  logic              reset,
  input  logic              res_valid,
  output logic              res_ready,
  input  reg_loc_t          res_loc,
  input  word_t             res_data,
  input  logic              hold,
  reg_access_execute.out    rf,
  input  reg_loc_t          rd_loc_1,
  input  reg_loc_t          rd_loc_2,
  output word_t             fwd_data_1,
  output word_t             fwd_data_2,
  output logic              hazard,
  output logic              empty
);
  wb_entry_t             head;
  logic                  full, push, pop;
  logic     [DEPTH-1:0]  ent_valid;
  reg_loc_t [DEPTH-1:0]  ent_loc;
  word_t    [DEPTH-1:0]  ent_data;
  assign res_ready = !full;
  assign push      = res_valid && !full && res_loc != '0;
  assign pop       = !empty && !hold;
  reg_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push       (push),
    .pop        (pop),
    .push_entry ('{loc: res_loc, data: res_data}),
    .head       (head),
    .full       (full),
    .empty      (empty),
    .ent_valid  (ent_valid),
    .ent_loc    (ent_loc),
    .ent_data   (ent_data)
  );
  assign rf.do_write   = pop;
  assign rf.write_loc  = head.loc;
  assign rf.write_data = head.data;
`ifdef RF_WB_BYPASS_EN
  function automatic word_t forward(input reg_loc_t loc, input word_t rd,
                                    input logic [DEPTH-1:0] v, input reg_loc_t [DEPTH-1:0] l,
                                    input word_t [DEPTH-1:0] d);
    word_t w = rd;
    for (int i = 0; i < DEPTH; i++) if (v[i] && l[i] == loc) w = d[i];
    return loc == '0 ? '0 : w;
  endfunction
  assign fwd_data_1 = forward(rd_loc_1, rf.read_data_1, ent_valid, ent_loc, ent_data);
  assign fwd_data_2 = forward(rd_loc_2, rf.read_data_2, ent_valid, ent_loc, ent_data);
  assign hazard     = 1'b0;
`else
  function automatic logic queued(input reg_loc_t loc, input logic [DEPTH-1:0] v,
                                  input reg_loc_t [DEPTH-1:0] l);
    logic hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) if (v[i] && l[i] == loc) hit = 1'b1;
    return hit && loc != '0;
  endfunction
  logic unused_ent_data;
  assign unused_ent_data = ^ent_data;
  assign fwd_data_1 = rd_loc_1 == '0 ? '0 : rf.read_data_1;
  assign fwd_data_2 = rd_loc_2 == '0 ? '0 : rf.read_data_2;
  assign hazard     = queued(rd_loc_1, ent_valid, ent_loc) || queued(rd_loc_2, ent_valid, ent_loc);
`endif
endmodule

// File: tb/tb_reg_writeback_queue.sv
// tb_reg_writeback_queue: randomized and directed checks against a queue-based reference model.
module tb_reg_writeback_queue;
  import rv_reg_pkg::*;
  localparam int DEPTH = 4;
  logic     clock = 1'b0;
  logic     reset = 1'b0;
  logic     res_valid = 1'b0, hold = 1'b0;
  logic     res_ready, hazard, empty;
  reg_loc_t res_loc = '0, rd_loc_1 = '0, rd_loc_2 = '0;
  word_t    res_data = '0, fwd_data_1, fwd_data_2;
  int       checks = 0, errors = 0;
  word_t    regs     [REG_COUNT] = '{default: '0};
  word_t    model_rf [REG_COUNT] = '{default: '0};
  wb_entry_t q[$];
  reg_access_execute rf_if ();
  reg_writeback_queue #(.DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .res_valid(res_valid), .res_ready(res_ready),
    .res_loc(res_loc), .res_data(res_data), .hold(hold), .rf(rf_if.out),
    .rd_loc_1(rd_loc_1), .rd_loc_2(rd_loc_2), .fwd_data_1(fwd_data_1),
    .fwd_data_2(fwd_data_2), .hazard(hazard), .empty(empty)
  );
  always #5 clock = ~clock;
  // Register file model: writes land on the negedge inside the do_write window.
  always @(negedge clock) if (rf_if.do_write && rf_if.write_loc != '0) regs[rf_if.write_loc] <= rf_if.write_data;
  assign rf_if.read_data_1 = regs[rd_loc_1];
  assign rf_if.read_data_2 = regs[rd_loc_2];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic in_queue(input reg_loc_t r);
    foreach (q[i]) if (q[i].loc == r) return r != '0;
    return 1'b0;
  endfunction
  function automatic word_t exp_fwd(input reg_loc_t r);
    word_t v = model_rf[r];
`ifdef RF_WB_BYPASS_EN
    foreach (q[i]) if (q[i].loc == r) v = q[i].data;
`endif
    return r == '0 ? '0 : v;
  endfunction
  // One clock cycle: drive at posedge+1, check at posedge+4, advance the model at the next posedge.
  task automatic cycle(input logic v, input reg_loc_t l, input word_t d, input logic h,
                       input reg_loc_t r1, input reg_loc_t r2);
    logic acc, dw;
    wb_entry_t hd;
    res_valid = v; res_loc = l; res_data = d; hold = h; rd_loc_1 = r1; rd_loc_2 = r2;
    #3;
    acc = v && q.size() < DEPTH;
    dw  = q.size() != 0 && !h;
    check("res_ready", res_ready, q.size() < DEPTH);
    check("empty", empty, q.size() == 0);
    check("do_write", rf_if.do_write, dw);
    if (dw) begin
      hd = q[0];
      check("write_loc", rf_if.write_loc, hd.loc);
      check("write_data", rf_if.write_data, hd.data);
    end
    check("fwd_data_1", fwd_data_1, exp_fwd(r1));
    check("fwd_data_2", fwd_data_2, exp_fwd(r2));
`ifdef RF_WB_BYPASS_EN
    check("hazard", hazard, 1'b0);
`else
    check("hazard", hazard, in_queue(r1) || in_queue(r2));
`endif
    @(posedge clock);
    if (dw) begin
      model_rf[hd.loc] = hd.data;
      void'(q.pop_front());
      check("rf_contents", regs[hd.loc], hd.data);
    end
    if (acc && l != '0) q.push_back('{loc: l, data: d});
    #1;
  endtask
  initial begin
    rd_loc_1 = 4'd7;
    #11;
    check("rst_do_write", rf_if.do_write, 1'b0);
    check("rst_write_loc", rf_if.write_loc, 4'd0);
    check("rst_write_data", rf_if.write_data, 32'd0);
    check("rst_empty", empty, 1'b1);
    check("rst_res_ready", res_ready, 1'b1);
    check("rst_hazard", hazard, 1'b0);
    check("rst_fwd_2", fwd_data_2, 32'd0);
    #1 reset = 1'b1;
    @(posedge clock); #1;
    cycle(1'b1, 4'd5, 32'h0000_00AA, 1'b0, 4'd5, 4'd0);
    cycle(1'b0, 4'd0, 32'd0, 1'b0, 4'd5, 4'd0);
    cycle(1'b0, 4'd0, 32'd0, 1'b0, 4'd5, 4'd5);
    check("x5_after_write", regs[5], 32'h0000_00AA);
    for (int i = 0; i < 5; i++) cycle(1'b1, 4'(i + 1), 32'h100 + 32'(i), 1'b1, 4'd2, 4'd4);
    repeat (5) cycle(1'b0, 4'd0, 32'd0, 1'b0, 4'd1, 4'd3);
    cycle(1'b1, 4'd3, 32'h11, 1'b1, 4'd3, 4'd0);
    cycle(1'b1, 4'd3, 32'h22, 1'b1, 4'd3, 4'd0);
    cycle(1'b0, 4'd0, 32'd0, 1'b1, 4'd3, 4'd0);
    check("fwd_newest_x3", fwd_data_1, exp_fwd(4'd3));
    repeat (3) cycle(1'b0, 4'd0, 32'd0, 1'b0, 4'd3, 4'd0);
    cycle(1'b1, 4'd0, 32'hDEAD, 1'b0, 4'd0, 4'd0);
    repeat (2) cycle(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 4'd0);
    for (int i = 0; i < 10; i++) cycle(1'b1, 4'(i + 1), $urandom, 1'b0, 4'(i), 4'(i + 1));
    repeat (2) cycle(1'b0, 4'd0, 32'd0, 1'b0, 4'd10, 4'd9);
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 3) != 0, 4'($urandom), $urandom, $urandom_range(0, 3) == 0,
            4'($urandom), 4'($urandom));
    repeat (DEPTH + 1) cycle(1'b0, 4'd0, 32'd0, 1'b0, 4'd1, 4'd2);
    for (int i = 0; i < 3; i++) cycle(1'b1, 4'(9 + i), 32'hC0 + 32'(i), 1'b1, 4'd9, 4'd10);
    res_valid = 1'b0; hold = 1'b0;
    #2 check("pre_reset_do_write", rf_if.do_write, 1'b1);
    reset = 1'b0;
    #1;
    check("mid_rst_do_write", rf_if.do_write, 1'b0);
    check("mid_rst_empty", empty, 1'b1);
    check("mid_rst_res_ready", res_ready, 1'b1);
    check("mid_rst_write_loc", rf_if.write_loc, 4'd0);
    q.delete();
    #4 reset = 1'b1;
    @(posedge clock); #1;
    repeat (4) cycle(1'b0, 4'd0, 32'd0, 1'b0, 4'd9, 4'd11);
    check("x9_not_written", regs[9], model_rf[9]);
    check("x11_not_written", regs[11], model_rf[11]);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/reg_writeback_queue.md
# reg_writeback_queue

Write-side initiator for the RV32E register file: buffers completed results from execute/memory in a small in-order queue and drains them, one per cycle, into the register file's write port. The register file drives `reg_access_execute.file`; this block drives the opposite `reg_access_execute.out` end. It also forwards not-yet-retired values to decode reads so decode never sees stale data. It sits between the execute/memory result bus and the register file.

## Interface
- `DEPTH`, 4: queue entries, power of two, 2..16.
- `clock`  in  1  system clock; all state on posedge.
- `reset`  in  1  asynchronous, active-low; clears all state.
- `res_valid`  in  1  producer has a result.
- `res_ready`  out  1  block accepts a result this cycle.
- `res_loc`  in  4  destination register x0..x15.
- `res_data`  in  32  result value.
- `hold`  in  1  suppresses draining (pipeline freeze / debug).
- `rf`  `reg_access_execute.out`  —  drives `write_loc`, `write_data`, `do_write`; samples `read_data_1`, `read_data_2`.
- `rd_loc_1`, `rd_loc_2`  in  4 each  locations decode is reading (same values decode places on `reg_access_decode`).
- `fwd_data_1`, `fwd_data_2`  out  32 each  forwarded operand values.
- `hazard`  out  1  operand not forwardable; decode must stall.
- `empty`  out  1  queue holds no entries.

## Operation
- Enqueue when `res_valid && res_ready`; `res_ready = !full`. No pass-through: a result always spends ≥1 cycle in the queue.
- Results with `res_loc == 0` are handshaken normally but discarded (x0 stays zero); not counted toward occupancy.
- Drain: when non-empty and `!hold`, head is presented: `rf.do_write=1`, `rf.write_loc/write_data` = head entry; head pops at the next posedge. Register file writes on the intervening negedge.
- `hold=1`: `rf.do_write=0`, head retained; enqueue continues until full.
- Simultaneous enqueue and pop when full is not possible (`res_ready=0`); when not full both occur in the same edge, count unchanged.
- Forwarding per operand n: if `rd_loc_n == 0` → 0; else newest valid entry (head included) with matching loc → its data; else `rf.read_data_n`. Purely combinational.
- `hazard` is 0 when bypass is compiled in.
- Pointers wrap modulo `DEPTH`; occupancy counter is `$clog2(DEPTH)+1` bits.

## Timing
- Reset values: `res_ready=1`, `rf.do_write=0`, `rf.write_loc=0`, `rf.write_data=0`, `empty=1`, `hazard=0`, queue invalid; `fwd_data_n` follows `rf.read_data_n` (0 for loc 0).
- Latency: result accepted at edge N drives `rf.do_write` from edge N to edge N+1 (absent `hold`); register updated at the negedge in that window.
- Throughput: one enqueue and one retire per cycle sustained.
- All `rf.*` write outputs come straight from registered storage; no combinational path from `res_*` to `rf.*`.
- Reset asserted mid-operation: queue flushed immediately, pending writes lost, `rf.do_write` drops asynchronously.

## Configuration
- `RF_WB_BYPASS_EN` defined: forwarding as above, `hazard` tied 0.
- Undefined: no match logic; `fwd_data_n = rf.read_data_n` (0 for loc 0); `hazard=1` when either nonzero `rd_loc_n` matches any valid queue entry.

## Structure
- Package `rv_reg_pkg`: `reg_loc_t` (4-bit), `word_t` (32-bit), `wb_entry_t` struct {loc, data}, `REG_COUNT=16`.
- Sub-module `reg_wb_fifo`: parameterized circular buffer of `wb_entry_t` exposing head, per-entry valid/loc/data vectors for match logic; top level holds handshake, drain and forwarding.

## Test plan
- Reset, then enqueue (x5, 0x0000_00AA) → `rf.do_write=1`, loc 5, data 0xAA for exactly one cycle; register file x5 reads 0xAA afterwards.
- `hold=1`, enqueue 5 results with DEPTH=4 → `res_ready` low after 4th; release hold → four writes in order, one per cycle, then `empty=1`.
- Enqueue x3=0x11 then x3=0x22 under hold, `rd_loc_1=3` → `fwd_data_1=0x22`; without bypass macro → `hazard=1`.
- Enqueue (x0, 0xDEAD) → no `rf.do_write`, `empty` stays 1, `rd_loc_2=0` gives `fwd_data_2=0`.
- Continuous stream of 10 results with `hold=0` → `res_ready` never drops, 10 writes, each one cycle after acceptance.
- Assert `reset` with 3 entries pending → `rf.do_write` drops immediately, `empty=1`, no further writes after release.
